// File: rtl/xadc_drp_scanner.sv
// xadc_drp_scanner
//   Walks NUM_CH XADC status registers over the DRP port, one read per
//   channel, and keeps the 12-bit results in a per-channel bank. User DRP
//   writes are granted only between scans.
//
//   Optional build macro: XADC_AVG_EN -- per-channel exponential average
//   (avg += (new - avg) >>> AVG_SHIFT) stored in place of the raw sample.
//
// Ports
//   clk, rst                 DRP clock, asynchronous active-low reset
//   scan_mode, start, eos    trigger selection (0: start, 1: eos)
//   usr_wr/addr/data/ack     user write request (level) and completion pulse
//   den/dwe/daddr/din        DRP request outputs
//   dout/drdy                DRP response inputs
//   res_valid/ch/data        per-channel result strobe
//   res_bank                 all stored results, channel i at [12i+11:12i]
//   scan_done, busy          pass-complete pulse, non-idle indicator
//   timeout_err, overrun     sticky error flags
module xadc_drp_scanner #(
    parameter int                  NUM_CH    = 4,
    parameter logic [7*NUM_CH-1:0] CH_ADDRS  = 28'h0608080,
    parameter int                  CH_W      = 2,
    parameter int                  TIMEOUT   = 63,
    parameter int                  AVG_SHIFT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 scan_mode,
    input  logic                 start,
    input  logic                 eos,
    input  logic                 usr_wr,
    input  logic [6:0]           usr_addr,
    input  logic [15:0]          usr_data,
    output logic                 usr_ack,
    output logic                 den,
    output logic                 dwe,
    output logic [6:0]           daddr,
    output logic [15:0]          din,
    input  logic [15:0]          dout,
    input  logic                 drdy,
    output logic                 res_valid,
    output logic [CH_W-1:0]      res_ch,
    output logic [11:0]          res_data,
    output logic [NUM_CH*12-1:0] res_bank,
    output logic                 scan_done,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 overrun
);
    localparam int TW = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, STORE, WR_ISSUE, WR_WAIT} state_t;

    state_t                  state_q, state_d;
    logic [CH_W-1:0]         idx_q, idx_d;
    logic                    pend_q, pend_d;
    logic [TW-1:0]           tcnt_q, tcnt_d;
    logic [11:0]             cap_q, cap_d;
    logic                    skip_q, skip_d;   // channel timed out: advance without storing
    logic [NUM_CH-1:0][11:0] bank_q, bank_d;
    logic                    terr_q, terr_d;
    logic                    ovr_q, ovr_d;
    logic                    ack_q, ack_d;

    logic                    trig, last, tmo;
    logic [11:0]             new_val;
    logic                    unused_ok;

    assign trig      = scan_mode ? eos : start;
    assign last      = (idx_q == CH_W'(NUM_CH - 1));
    assign tmo       = (tcnt_q == TW'(TIMEOUT));
    assign unused_ok = ^{dout[3:0], AVG_SHIFT[0]};

`ifdef XADC_AVG_EN
    logic [NUM_CH-1:0]  seeded_q, seeded_d;
    logic signed [12:0] avg_old, diff, step, avg_new;

    assign avg_old = $signed({1'b0, bank_q[idx_q]});
    assign diff    = $signed({1'b0, cap_q}) - avg_old;
    assign step    = diff >>> AVG_SHIFT;
    assign avg_new = avg_old + step;
    // first sample after reset seeds the average directly
    assign new_val = seeded_q[idx_q] ? avg_new[11:0] : cap_q;
`else
    assign new_val = cap_q;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pend_d    = pend_q;
        tcnt_d    = tcnt_q;
        cap_d     = cap_q;
        skip_d    = skip_q;
        bank_d    = bank_q;
        terr_d    = terr_q;
        ovr_d     = ovr_q;
        ack_d     = 1'b0;
`ifdef XADC_AVG_EN
        seeded_d  = seeded_q;
`endif
        den       = 1'b0;
        dwe       = 1'b0;
        daddr     = 7'd0;
        din       = 16'd0;
        res_valid = 1'b0;
        res_ch    = '0;
        res_data  = 12'd0;
        scan_done = 1'b0;

        // A trigger that is not consumed this cycle is queued (one deep).
        if (trig && (state_q != IDLE || (usr_wr && !ack_q))) begin
            if (pend_q) ovr_d = 1'b1;
            else        pend_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                // ack_q blocks the still-held request in the ack cycle itself
                if (usr_wr && !ack_q) begin
                    state_d = WR_ISSUE;
                end else if (pend_q || trig) begin
                    state_d = RD_ISSUE;
                    idx_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            RD_ISSUE: begin
                den     = 1'b1;
                daddr   = CH_ADDRS[7*int'(idx_q) +: 7];
                tcnt_d  = '0;
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (drdy) begin
                    cap_d   = dout[15:4];
                    skip_d  = 1'b0;
                    state_d = STORE;
                end else if (tmo) begin
                    terr_d  = 1'b1;
                    skip_d  = 1'b1;
                    state_d = STORE;
                end else begin
                    tcnt_d  = tcnt_q + TW'(1);
                end
            end
            STORE: begin
                if (!skip_q) begin
                    bank_d[idx_q] = new_val;
                    res_valid     = 1'b1;
                    res_ch        = idx_q;
                    res_data      = new_val;
`ifdef XADC_AVG_EN
                    seeded_d[idx_q] = 1'b1;
`endif
                end
                if (last) begin
                    scan_done = 1'b1;
                    idx_d     = '0;
                    state_d   = IDLE;
                end else begin
                    idx_d     = idx_q + CH_W'(1);
                    state_d   = RD_ISSUE;
                end
            end
            WR_ISSUE: begin
                den     = 1'b1;
                dwe     = 1'b1;
                daddr   = usr_addr;
                din     = usr_data;
                tcnt_d  = '0;
                state_d = WR_WAIT;
            end
            WR_WAIT: begin
                if (drdy || tmo) begin
                    if (!drdy) terr_d = 1'b1;
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tcnt_d  = tcnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            pend_q   <= 1'b0;
            tcnt_q   <= '0;
            cap_q    <= 12'd0;
            skip_q   <= 1'b0;
            bank_q   <= '0;
            terr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            ack_q    <= 1'b0;
`ifdef XADC_AVG_EN
            seeded_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            tcnt_q   <= tcnt_d;
            cap_q    <= cap_d;
            skip_q   <= skip_d;
            bank_q   <= bank_d;
            terr_q   <= terr_d;
            ovr_q    <= ovr_d;
            ack_q    <= ack_d;
`ifdef XADC_AVG_EN
            seeded_q <= seeded_d;
`endif
        end
    end

    assign busy        = (state_q != IDLE);
    assign usr_ack     = ack_q;
    assign timeout_err = terr_q;
    assign overrun     = ovr_q;
    assign res_bank    = bank_q;

endmodule
